tmds_decoder: RTL and testbench

- Single-channel TMDS receiver back end: accepts 10-bit parallel symbols from a deserializer and decodes them into 8-bit pixel data or the 2-bit control value (C0/C1, i.e. HS/VS on channel 0).
- Contains a symbol-alignment state machine. It hunts for control-token runs, requests bitslips from the deserializer until word alignment is found, and reports lock.
- One instance per TMDS channel on the sink side of the DVI link, in the pixel clock domain.

---
 rtl/tmds_decoder.sv | 149 ++++++++++++++
 tb/tb_tmds_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS channel receive back end: decodes 10-bit symbols to pixel bytes or
// control bits and drives word alignment of the deserializer via bitslip.
module tmds_decoder #(
  parameter int unsigned LOCK_RUN       = 16,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned SLIP_WAIT      = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_word,
  output logic [7:0] o_data,
  output logic       o_de,
  output logic       o_c0,
  output logic       o_c1,
  output logic       o_locked,
  output logic       o_bitslip
);

  localparam int unsigned RUN_W = $clog2(LOCK_RUN + 1);
  localparam int unsigned TMO_W = $clog2(SEARCH_TIMEOUT);
  localparam int unsigned SW_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_RUN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SW_W-1:0]  SW_LAST  = SW_W'(SLIP_WAIT - 1);

  localparam logic [1:0] ST_SEARCH    = 2'd0;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

  logic [1:0]       state, state_n;
  logic [RUN_W-1:0] run_cnt, run_n, run_inc;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic [SW_W-1:0]  slip_cnt, slip_n;
  logic             bitslip_n, locked_n;
  logic             is_ctrl, run_complete;
  logic [1:0]       tok_c;
  logic [7:0]       d, dec;

  always_comb begin
    is_ctrl = 1'b1;
    tok_c   = 2'b00;
    case (i_word)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    d      = i_word[9] ? ~i_word[7:0] : i_word[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec[i] = i_word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // Saturated run keeps reporting completion on every further token so a
  // steady control period continually refreshes the lock timeout.
  assign run_inc      = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
  assign run_complete = is_ctrl && (state != ST_SLIP_WAIT) && (run_inc == RUN_MAX);

  always_comb begin
    state_n   = state;
    tmo_n     = tmo_cnt;
    slip_n    = slip_cnt;
    run_n     = is_ctrl ? run_inc : '0;
    bitslip_n = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (run_complete) begin
          state_n = ST_LOCKED;
          tmo_n   = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n   = ST_SLIP_WAIT;
          bitslip_n = 1'b1;
          run_n     = '0;
          tmo_n     = '0;
          slip_n    = '0;
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
        end
      end
      ST_SLIP_WAIT: begin
        run_n = '0;
        if (slip_cnt == SW_LAST) begin
          state_n = ST_SEARCH;
          tmo_n   = '0;
          slip_n  = '0;
        end else begin
          slip_n = slip_cnt + SW_W'(1);
        end
      end
      ST_LOCKED: begin
        if (run_complete) begin
          tmo_n = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = ST_SEARCH;
          tmo_n   = '0;
          run_n   = '0;
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
        end
      end
      default: begin
        state_n = ST_SEARCH;
        tmo_n   = '0;
        run_n   = '0;
        slip_n  = '0;
      end
    endcase
    locked_n = (state_n == ST_LOCKED);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_SEARCH;
      run_cnt   <= '0;
      tmo_cnt   <= '0;
      slip_cnt  <= '0;
      o_data    <= '0;
      o_de      <= 1'b0;
      o_c0      <= 1'b0;
      o_c1      <= 1'b0;
      o_locked  <= 1'b0;
      o_bitslip <= 1'b0;
    end else begin
      state     <= state_n;
      run_cnt   <= run_n;
      tmo_cnt   <= tmo_n;
      slip_cnt  <= slip_n;
      o_locked  <= locked_n;
      o_bitslip <= bitslip_n;
      if (is_ctrl) begin
        o_data <= '0;
        o_de   <= 1'b0;
        o_c0   <= tok_c[0];
        o_c1   <= tok_c[1];
      end else begin
        o_data <= dec;
        o_de   <= locked_n;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: expectations are queued when a symbol is
// driven and checked against the registered outputs one cycle later.
module tb_tmds_decoder;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [9:0] i_word;
  logic [7:0] o_data;
  logic       o_de, o_c0, o_c1, o_locked, o_bitslip;

  tmds_decoder #(
    .LOCK_RUN      (16),
    .SEARCH_TIMEOUT(2048),
    .SLIP_WAIT     (16)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_word   (i_word),
    .o_data   (o_data),
    .o_de     (o_de),
    .o_c0     (o_c0),
    .o_c1     (o_c1),
    .o_locked (o_locked),
    .o_bitslip(o_bitslip)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] data;
    logic       de;
    logic [1:0] c;
    logic       locked;
    logic       slip;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [1:0]  cur_c;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [9:0] w,
                      input logic [7:0] ed, input logic ede, input logic el, input logic es);
    exp_t e, g;
    e.data = ed; e.de = ede; e.c = cur_c; e.locked = el; e.slip = es;
    sb.push_back(e);
    i_rst  = rst;
    i_word = w;
    @(posedge i_clk);
    #1;
    g = sb.pop_front();
    cmp($sformatf("%s.data", tag), o_data, g.data);
    cmp($sformatf("%s.de", tag), 8'(o_de), 8'(g.de));
    cmp($sformatf("%s.c0", tag), 8'(o_c0), 8'(g.c[0]));
    cmp($sformatf("%s.c1", tag), 8'(o_c1), 8'(g.c[1]));
    cmp($sformatf("%s.locked", tag), 8'(o_locked), 8'(g.locked));
    cmp($sformatf("%s.bitslip", tag), 8'(o_bitslip), 8'(g.slip));
  endtask

  task automatic tok(input string tag, input logic [1:0] c, input logic el);
    logic [9:0] w;
    case (c)
      2'b00:   w = 10'h354;
      2'b01:   w = 10'h0AB;
      2'b10:   w = 10'h154;
      default: w = 10'h2AB;
    endcase
    cur_c = c;
    step(tag, 1'b0, w, 8'h00, 1'b0, el, 1'b0);
  endtask

  task automatic dat(input string tag, input logic [9:0] w, input logic [7:0] b,
                     input logic el, input logic es);
    step(tag, 1'b0, w, b, el, el, es);
  endtask

  task automatic rst_step(input string tag, input logic [9:0] w);
    cur_c = 2'b00;
    step(tag, 1'b1, w, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference 8b/10b TMDS encoder (transition minimisation + simple inversion rule).
  function automatic logic [9:0] enc(input logic [7:0] b);
    logic [8:0]  q;
    int unsigned n1, nq;
    logic        xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += 32'(b[i]);
    xn   = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
    q    = '0;
    q[0] = b[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
    q[8] = ~xn;
    nq = 0;
    for (int i = 0; i < 8; i++) nq += 32'(q[i]);
    if (nq > 4) return {1'b1, q[8], ~q[7:0]};
    return {1'b0, q[8], q[7:0]};
  endfunction

  initial begin
    logic [7:0] rb;
    i_rst  = 1'b1;
    i_word = 10'h000;
    cur_c  = 2'b00;

    rst_step("reset0", 10'h000);
    rst_step("reset1", 10'h2AB);

    // Control decode and lock after 16 tokens
    for (int i = 1; i <= 20; i++) tok($sformatf("t1.tok%0d", i), 2'b11, (i >= 16));
    tok("t1.tok154", 2'b10, 1'b1);
    dat("t1.hold", 10'h100, 8'h00, 1'b1, 1'b0);

    // Data decode while locked
    rst_step("t2.rst", 10'h000);
    for (int i = 1; i <= 16; i++) tok($sformatf("t2.tok%0d", i), 2'b00, (i == 16));
    dat("t2.w100", 10'h100, 8'h00, 1'b1, 1'b0);
    dat("t2.w200", 10'h200, 8'hFF, 1'b1, 1'b0);
    dat("t2.enc10", enc(8'h10), 8'h10, 1'b1, 1'b0);
    dat("t2.encA5", enc(8'hA5), 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      dat($sformatf("t2.rnd%0d", i), enc(rb), rb, 1'b1, 1'b0);
    end

    // Bitslip pulses on the 2048th edge after reset and every 2064 edges after
    rst_step("t3.rst", 10'h100);
    for (int k = 1; k <= 4116; k++)
      dat($sformatf("t3.c%0d", k), 10'h100, 8'h00, 1'b0, (k == 2048 || k == 4112));

    // Lock loss after 2048 data symbols, no bitslip, then relock
    rst_step("t4.rst", 10'h000);
    for (int i = 1; i <= 16; i++) tok($sformatf("t4.tok%0d", i), 2'b00, (i == 16));
    for (int k = 1; k <= 2048; k++)
      dat($sformatf("t4.d%0d", k), 10'h100, 8'h00, (k < 2048), 1'b0);
    for (int i = 1; i <= 16; i++) tok($sformatf("t4.re%0d", i), 2'b01, (i == 16));

    // 16th token coincides with search timeout: lock wins
    rst_step("t5.rst", 10'h000);
    for (int k = 1; k <= 2032; k++)
      dat($sformatf("t5.d%0d", k), 10'h100, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) tok($sformatf("t5.tok%0d", i), 2'b00, (i == 16));
    dat("t5.after", 10'h100, 8'h00, 1'b1, 1'b0);

    // Reset while locked and streaming data, then 15 vs 16 token runs
    dat("t6.pre", 10'h200, 8'hFF, 1'b1, 1'b0);
    rst_step("t6.rst", 10'h200);
    for (int i = 1; i <= 15; i++) tok($sformatf("t6.r15_%0d", i), 2'b01, 1'b0);
    dat("t6.brk", 10'h100, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) tok($sformatf("t6.r16_%0d", i), 2'b01, (i == 16));
    dat("t6.data", 10'h200, 8'hFF, 1'b1, 1'b0);

    // Reset on the edge that would have issued a bitslip cancels it
    rst_step("t7.rst", 10'h100);
    for (int k = 1; k <= 2047; k++)
      dat($sformatf("t7.d%0d", k), 10'h100, 8'h00, 1'b0, 1'b0);
    rst_step("t7.cancel", 10'h100);
    dat("t7.post", 10'h100, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
